classify_window_ctrl: RTL and testbench

CLASSIFY_WINDOW_CTRL -- requirements
Module: classify_window_ctrl

---
 rtl/snn_pkg.sv | 26 ++
 rtl/spike_counter_bank.sv | 32 +++
 rtl/classify_window_ctrl.sv | 118 +++++++++++
 tb/tb_classify_window_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network classification blocks.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_SCAN   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  localparam int DEF_NUM_NODES  = 10;
  localparam int DEF_WINDOW_LEN = 100;
  localparam int DEF_CNT_W      = 16;
  localparam int MAX_CNT_W      = 32;

  // Increment a w-bit value (zero-extended to MAX_CNT_W) by inc, pinning at 2^w-1.
  function automatic logic [MAX_CNT_W-1:0] sat_add(input logic [MAX_CNT_W-1:0] a,
                                                   input logic                 inc,
                                                   input int unsigned          w);
    logic [MAX_CNT_W-1:0] lim;
    lim = (w >= MAX_CNT_W) ? {MAX_CNT_W{1'b1}} : ~({MAX_CNT_W{1'b1}} << w);
    if (inc && (a != lim)) return a + MAX_CNT_W'(1);
    return a;
  endfunction

endpackage

// File: rtl/spike_counter_bank.sv
// Per-neuron saturating spike counters with a single indexed read port.
module spike_counter_bank
  import snn_pkg::*;
#(
  parameter int NUM_NODES = DEF_NUM_NODES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int IDX_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_en,
  input  logic                 clr,
  input  logic [NUM_NODES-1:0] nodes,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [CNT_W-1:0]     rd_cnt
);

  logic [CNT_W-1:0] cnt_q [NUM_NODES];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      for (int i = 0; i < NUM_NODES; i++) cnt_q[i] <= '0;
    end else if (inc_en) begin
      for (int i = 0; i < NUM_NODES; i++)
        cnt_q[i] <= CNT_W'(sat_add(MAX_CNT_W'(cnt_q[i]), nodes[i], CNT_W));
    end
  end

  // Out-of-range pointer values (non power-of-two node counts) read as zero.
  assign rd_cnt = (int'(rd_idx) < NUM_NODES) ? cnt_q[rd_idx] : '0;

endmodule

// File: rtl/classify_window_ctrl.sv
// Accumulates spikes over a fixed window of timesteps, then scans for the
// neuron with the most spikes and presents it on a valid/ready result port.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | waiting for start_i
//   ST_ACCUM  | accepting timesteps until WINDOW_LEN have been taken
//   ST_SCAN   | comparing one counter per cycle, lowest index first
//   ST_OUTPUT | result valid, waiting for class_ready_i
module classify_window_ctrl
  import snn_pkg::*;
#(
  parameter int NUM_NODES  = DEF_NUM_NODES,
  parameter int WINDOW_LEN = DEF_WINDOW_LEN,
  parameter int CNT_W      = DEF_CNT_W,
  localparam int IDX_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 step_valid_i,
  output logic                 step_ready_o,
  input  logic [NUM_NODES-1:0] nodes_i,
  output logic                 class_valid_o,
  input  logic                 class_ready_i,
  output logic [IDX_W-1:0]     class_o,
  output logic [CNT_W-1:0]     class_count_o,
  output logic                 no_spike_o,
  output logic                 busy_o
);

  localparam int STEP_W = $clog2(WINDOW_LEN + 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] steps_left_q;
  logic [IDX_W-1:0]  scan_idx_q;
  logic [IDX_W-1:0]  best_idx_q;
  logic [CNT_W-1:0]  best_cnt_q;
  logic [CNT_W-1:0]  rd_cnt;

  logic step_acc, last_step, scan_last, handshake, start_win;

  assign start_win = (state_q == ST_IDLE) && start_i;
  assign step_acc  = (state_q == ST_ACCUM) && step_valid_i;
  assign last_step = step_acc && (steps_left_q == STEP_W'(1));
  assign scan_last = (scan_idx_q == IDX_W'(NUM_NODES - 1));
  assign handshake = (state_q == ST_OUTPUT) && class_ready_i;

  spike_counter_bank #(
    .NUM_NODES(NUM_NODES),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_en(step_acc),
    .clr   (handshake),
    .nodes (nodes_i),
    .rd_idx(scan_idx_q),
    .rd_cnt(rd_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_i)   state_d = ST_ACCUM;
      ST_ACCUM:  if (last_step) state_d = ST_SCAN;
      ST_SCAN:   if (scan_last) state_d = ST_OUTPUT;
      ST_OUTPUT: if (class_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Step down-counter is loaded on start and terminates at one remaining step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      steps_left_q <= '0;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
    end else begin
      if (start_win) begin
        steps_left_q <= STEP_W'(WINDOW_LEN);
        scan_idx_q   <= '0;
        best_idx_q   <= '0;
        best_cnt_q   <= '0;
      end else if (step_acc) begin
        steps_left_q <= steps_left_q - STEP_W'(1);
      end
      if (state_q == ST_SCAN) begin
        if (rd_cnt > best_cnt_q) begin
          best_cnt_q <= rd_cnt;
          best_idx_q <= scan_idx_q;
        end
        scan_idx_q <= scan_last ? '0 : scan_idx_q + IDX_W'(1);
      end
      if (handshake) begin
        steps_left_q <= '0;
        scan_idx_q   <= '0;
        best_idx_q   <= '0;
        best_cnt_q   <= '0;
      end
    end
  end

  assign step_ready_o  = (state_q == ST_ACCUM);
  assign class_valid_o = (state_q == ST_OUTPUT);
  assign busy_o        = (state_q != ST_IDLE);
  assign class_o       = best_idx_q;
  assign class_count_o = best_cnt_q;
  assign no_spike_o    = (state_q == ST_OUTPUT) && (best_cnt_q == '0);

endmodule

// File: tb/tb_classify_window_ctrl.sv
// Randomized bench for classify_window_ctrl: two instances (wide counters and
// narrow saturating counters) checked against a per-window spike-count model.
module tb_classify_window_ctrl;

  localparam int N = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i;
  logic       start[2], sv[2], crdy[2];
  logic [3:0] nodes[2];
  logic       srdy[2], cval[2], nspk[2], busy[2];
  logic [1:0] cls[2];
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int win[2]  = '{5, 12};
  int cmax[2] = '{65535, 7};

  classify_window_ctrl #(.NUM_NODES(4), .WINDOW_LEN(5), .CNT_W(16)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start[0]),
    .step_valid_i(sv[0]), .step_ready_o(srdy[0]), .nodes_i(nodes[0]),
    .class_valid_o(cval[0]), .class_ready_i(crdy[0]), .class_o(cls[0]),
    .class_count_o(cnt_a), .no_spike_o(nspk[0]), .busy_o(busy[0])
  );

  classify_window_ctrl #(.NUM_NODES(4), .WINDOW_LEN(12), .CNT_W(3)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start[1]),
    .step_valid_i(sv[1]), .step_ready_o(srdy[1]), .nodes_i(nodes[1]),
    .class_valid_o(cval[1]), .class_ready_i(crdy[1]), .class_o(cls[1]),
    .class_count_o(cnt_b), .no_spike_o(nspk[1]), .busy_o(busy[1])
  );

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int count_of(input int d);
    return (d == 0) ? int'(cnt_a) : int'(cnt_b);
  endfunction

  task automatic run_window(input int d, input logic [3:0] pat[$], input int gap_at,
                            input int gap_len, input int rdy_dly, input string tag);
    int ref_cnt[4];
    int best, bidx, lat;
    bit all_zero;
    for (int i = 0; i < N; i++) ref_cnt[i] = 0;
    @(negedge clk_i); start[d] = 1'b1;
    @(negedge clk_i); start[d] = 1'b0;
    check_val({tag, "_busy"}, longint'(busy[d]), 1);
    foreach (pat[k]) begin
      if (k == gap_at) begin
        sv[d] = 1'b0;
        nodes[d] = 4'($urandom);
        repeat (gap_len) @(negedge clk_i);
        check_val({tag, "_gap_ready"}, longint'(srdy[d]), 1);
        check_val({tag, "_gap_noval"}, longint'(cval[d]), 0);
      end
      check_val({tag, "_step_ready"}, longint'(srdy[d]), 1);
      sv[d] = 1'b1;
      nodes[d] = pat[k];
      start[d] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) if (pat[k][i]) ref_cnt[i]++;
      @(negedge clk_i);
    end
    sv[d] = 1'b0;
    start[d] = 1'b0;
    nodes[d] = 4'($urandom);
    lat = 1;
    while (!cval[d] && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    check_val({tag, "_latency"}, lat, N + 1);
    best = 0; bidx = 0; all_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (ref_cnt[i] > cmax[d]) ref_cnt[i] = cmax[d];
      if (ref_cnt[i] != 0) all_zero = 1'b0;
      if (ref_cnt[i] > best) begin best = ref_cnt[i]; bidx = i; end
    end
    check_val({tag, "_class"}, longint'(cls[d]), bidx);
    check_val({tag, "_count"}, count_of(d), best);
    check_val({tag, "_nospike"}, longint'(nspk[d]), longint'(all_zero));
    if (rdy_dly > 0) begin
      repeat (rdy_dly) @(negedge clk_i);
      check_val({tag, "_hold_valid"}, longint'(cval[d]), 1);
      check_val({tag, "_hold_class"}, longint'(cls[d]), bidx);
      check_val({tag, "_hold_count"}, count_of(d), best);
      check_val({tag, "_hold_nospike"}, longint'(nspk[d]), longint'(all_zero));
    end
    crdy[d] = 1'b1;
    start[d] = 1'b1;
    @(negedge clk_i);
    crdy[d] = 1'b0;
    start[d] = 1'b0;
    check_val({tag, "_done_valid"}, longint'(cval[d]), 0);
    check_val({tag, "_done_busy"}, longint'(busy[d]), 0);
    @(negedge clk_i);
    check_val({tag, "_no_chain"}, longint'(busy[d]), 0);
  endtask

  logic [3:0] q[$];

  initial begin
    rst_i = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; sv[d] = 1'b0; crdy[d] = 1'b0; nodes[d] = '0;
    end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("rst_ready", longint'(srdy[0]), 0);
    check_val("rst_valid", longint'(cval[0]), 0);
    check_val("rst_class", longint'(cls[0]), 0);
    check_val("rst_count", count_of(0), 0);
    check_val("rst_nospike", longint'(nspk[0]), 0);
    check_val("rst_busy", longint'(busy[0]), 0);

    q = '{4'b0110, 4'b0100, 4'b0110, 4'b0100, 4'b0100};
    run_window(0, q, -1, 0, 0, "basic");
    check_val("basic_expect_idle", longint'(busy[0]), 0);

    q = '{4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b0001};
    run_window(0, q, -1, 0, 2, "tie");

    q = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    run_window(0, q, -1, 0, 1, "nospike");

    q = '{4'b1001, 4'b0011, 4'b1000, 4'b1101, 4'b0010};
    run_window(0, q, 2, 7, 10, "backpressure");

    q = {};
    for (int k = 0; k < 12; k++) q.push_back(4'($urandom) | 4'b0001);
    run_window(1, q, -1, 0, 3, "saturate");

    // Partial window with node 3 spiking is discarded by reset.
    @(negedge clk_i); start[0] = 1'b1;
    @(negedge clk_i); start[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sv[0] = 1'b1; nodes[0] = 4'b1000;
      @(negedge clk_i);
    end
    sv[0] = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_val("midrst_busy", longint'(busy[0]), 0);
    check_val("midrst_ready", longint'(srdy[0]), 0);
    repeat (8) @(negedge clk_i);
    check_val("midrst_noresult", longint'(cval[0]), 0);
    q = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    run_window(0, q, -1, 0, 0, "midrst_fresh");

    for (int r = 0; r < 8; r++) begin
      int d;
      d = r % 2;
      q = {};
      for (int k = 0; k < win[d]; k++) q.push_back(4'($urandom));
      run_window(d, q, $urandom_range(0, win[d] - 1), $urandom_range(1, 6),
                 $urandom_range(0, 5), $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
